echo_peak_detector: RTL and testbench

- Sits directly downstream of the trigger-averaging stage and consumes its averaged frames.
- Input frames are delimited by tlast, SAMPLES_PER_FRAME signed samples each.
- Scans each frame past a blanking window and finds the peak sample value and its index.
- Emits one AXIS result beat per frame: peak, index, frame count and status flags, for the echo/range logic.

---
 rtl/echo_peak_detector.sv | 168 ++++++++++++++++
 tb/tb_echo_peak_detector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_peak_detector.sv
// echo_peak_detector
//
// Purpose: scans each averaged frame coming out of the trigger-averaging stage,
// skipping the leading blanking window, and reports the peak sample and its
// index as a single 64-bit AXIS beat for the echo/range logic.
//
// Ports:
//   s00_axis_aclk    clock for both AXIS interfaces
//   s00_axis_areset  synchronous, active-high reset
//   s00_axis_*       sample stream in (tstrb ignored), frames delimited by tlast
//   threshold        signed detection threshold, sampled on the frame-end cycle
//   m00_axis_*       result stream out, one-beat packets
//                    tdata [31:0] peak, [47:32] peak index, [63:48] frame count
//                    tuser bit0 peak >= threshold, bit1 frame length error
//
// Build option: define ECHO_PEAK_ABS_EN to search on |sample| instead of the
// signed value (magnitude of the most negative value saturates to the most
// positive value, running max starts from 0, reported peak is the magnitude).
//
// state | meaning
// ------+---------------------------------------------------------------
// SCAN  | accepting samples, tracking running max and its index
// HOLD  | result beat presented, input stalled until downstream handshake

module echo_peak_detector #(
  parameter int DATA_WIDTH        = 32,
  parameter int SAMPLES_PER_FRAME = 768,
  parameter int BLANK_SAMPLES     = 16,
  parameter int INDEX_WIDTH       = 16
) (
  input  logic                      s00_axis_aclk,
  input  logic                      s00_axis_areset,
  input  logic                      s00_axis_tvalid,
  input  logic                      s00_axis_tlast,
  input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                      s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]     threshold,
  input  logic                      m00_axis_tready,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  output logic [63:0]               m00_axis_tdata,
  output logic [7:0]                m00_axis_tstrb,
  output logic [1:0]                m00_axis_tuser
);

  // The beat counter is kept one bit wider than both the reported index and
  // the frame length so it can track the real position even when the
  // reported index has to saturate.
  localparam int CNT_W = ((INDEX_WIDTH > $clog2(SAMPLES_PER_FRAME)) ?
                          INDEX_WIDTH : $clog2(SAMPLES_PER_FRAME)) + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(SAMPLES_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] FIRST_SEARCH = CNT_W'(BLANK_SAMPLES);
  localparam logic [CNT_W-1:0] IDX_LIMIT    =
    {{(CNT_W-INDEX_WIDTH){1'b0}}, {INDEX_WIDTH{1'b1}}};

  localparam logic signed [DATA_WIDTH-1:0] VAL_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] VAL_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

`ifdef ECHO_PEAK_ABS_EN
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = '0;
`else
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = VAL_MIN;
`endif

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                        state;
  logic [CNT_W-1:0]              beat_cnt;
  logic [INDEX_WIDTH-1:0]        frame_cnt;
  logic signed [DATA_WIDTH-1:0]  run_max;
  logic [INDEX_WIDTH-1:0]        run_idx;

  logic signed [DATA_WIDTH-1:0]  sample;
  logic signed [DATA_WIDTH-1:0]  key;
  logic signed [DATA_WIDTH-1:0]  nxt_max;
  logic [INDEX_WIDTH-1:0]        beat_idx;
  logic [INDEX_WIDTH-1:0]        nxt_idx;
  logic [31:0]                   peak_ext;
  logic                          accept;
  logic                          at_last_beat;
  logic                          frame_end;
  logic                          take;
  logic                          len_err;
  logic                          thr_hit;

  logic unused_ok;
  assign unused_ok = ^s00_axis_tstrb;

  assign sample = s00_axis_tdata;

  always_comb begin
    key = sample;
`ifdef ECHO_PEAK_ABS_EN
    if (sample == VAL_MIN) begin
      key = VAL_MAX;
    end else if (sample[DATA_WIDTH-1]) begin
      key = -sample;
    end
`endif
  end

  assign beat_idx     = (beat_cnt > IDX_LIMIT) ? '1 : beat_cnt[INDEX_WIDTH-1:0];
  assign accept       = (state == SCAN) && s00_axis_tvalid;
  assign at_last_beat = (beat_cnt == LAST_BEAT);
  assign frame_end    = accept && (s00_axis_tlast || at_last_beat);

  // Strict compare so a later equal value never displaces the earliest index.
  assign take    = accept && (beat_cnt >= FIRST_SEARCH) && (key > run_max);
  assign nxt_max = take ? key : run_max;
  assign nxt_idx = take ? beat_idx : run_idx;

  // Size cast of a signed value sign-extends or truncates as needed.
  assign peak_ext = 32'(nxt_max);
  assign thr_hit  = (nxt_max >= $signed(threshold));
  // Error whenever tlast and the nominal last index disagree.
  assign len_err  = (s00_axis_tlast != at_last_beat);

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state           <= SCAN;
      beat_cnt        <= '0;
      frame_cnt       <= '0;
      run_max         <= MAX_INIT;
      run_idx         <= '1;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tuser  <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (accept) begin
            if (frame_end) begin
              m00_axis_tvalid <= 1'b1;
              m00_axis_tdata  <= {16'(frame_cnt), 16'(nxt_idx), peak_ext};
              m00_axis_tuser  <= {len_err, thr_hit};
              run_max         <= MAX_INIT;
              run_idx         <= '1;
              beat_cnt        <= '0;
              state           <= HOLD;
            end else begin
              run_max  <= nxt_max;
              run_idx  <= nxt_idx;
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
            frame_cnt       <= frame_cnt + 1'b1;
            state           <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign s00_axis_tready = (state == SCAN);
  assign m00_axis_tlast  = m00_axis_tvalid;
  assign m00_axis_tstrb  = 8'hFF;

endmodule

// File: tb/tb_echo_peak_detector.sv
// Testbench for echo_peak_detector: directed frames from the test plan plus
// randomized frames, each result compared against a frame-level reference
// model (peak search over a sample array).

module tb_echo_peak_detector;

  localparam int DW    = 32;
  localparam int SPF   = 768;
  localparam int BLANK = 16;
  localparam int IW    = 16;

`ifdef ECHO_PEAK_ABS_EN
  localparam bit ABS_MODE = 1'b1;
`else
  localparam bit ABS_MODE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            s_tvalid;
  logic            s_tlast;
  logic [DW-1:0]   s_tdata;
  logic [DW/8-1:0] s_tstrb;
  logic            s_tready;
  logic [DW-1:0]   threshold;
  logic            m_tready;
  logic            m_tvalid;
  logic            m_tlast;
  logic [63:0]     m_tdata;
  logic [7:0]      m_tstrb;
  logic [1:0]      m_tuser;

  int total = 0;
  int bad   = 0;
  int frame_cnt_exp = 0;
  int smp[$];

  always #5 clk = ~clk;

  echo_peak_detector #(
    .DATA_WIDTH(DW),
    .SAMPLES_PER_FRAME(SPF),
    .BLANK_SAMPLES(BLANK),
    .INDEX_WIDTH(IW)
  ) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(rst),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast (s_tlast),
    .s00_axis_tdata (s_tdata),
    .s00_axis_tstrb (s_tstrb),
    .s00_axis_tready(s_tready),
    .threshold      (threshold),
    .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast (m_tlast),
    .m00_axis_tdata (m_tdata),
    .m00_axis_tstrb (m_tstrb),
    .m00_axis_tuser (m_tuser)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: best search key over indices BLANK..n-1, earliest index wins ties.
  task automatic model(input int n, input bit has_tlast, input int thr,
                       output logic [63:0] data, output logic [1:0] user);
    longint best;
    longint key;
    int     bidx;
    best = ABS_MODE ? 64'sd0 : -64'sd2147483648;
    bidx = 'hFFFF;
    for (int i = BLANK; i < n; i++) begin
      key = longint'(smp[i]);
      if (ABS_MODE) begin
        if (key < 0) key = -key;
        if (key > 64'sd2147483647) key = 64'sd2147483647;
      end
      if (key > best) begin
        best = key;
        bidx = i;
      end
    end
    data    = {16'(frame_cnt_exp), 16'(bidx), 32'(best)};
    user[0] = (best >= longint'(thr));
    user[1] = has_tlast ? (n != SPF) : 1'b1;
  endtask

  function automatic int rnd_sample();
    int r;
    r = int'($urandom_range(15, 0));
    if (r == 0) return 32'sh80000000;
    if (r == 1) return 32'sh7FFFFFFF;
    if (r < 7)  return int'($urandom_range(20, 0)) - 10;
    return int'($urandom);
  endfunction

  // Called #1 after a posedge with the DUT in SCAN.
  task automatic send_frame(input int n, input bit has_tlast, input int thr, input int max_gap);
    threshold = thr;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = smp[i];
      s_tlast  = has_tlast && (i == n - 1);
      if (i == n - 1) begin
        check("s_tready_scan", 64'(s_tready), 64'd1);
        check("tvalid_before_end", 64'(m_tvalid), 64'd0);
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
    check("latency_tvalid", 64'(m_tvalid), 64'd1);
  endtask

  task automatic expect_result(input string tag, input int n, input bit has_tlast,
                               input int thr, input int hold_cycles);
    logic [63:0] ed;
    logic [1:0]  eu;
    model(n, has_tlast, thr, ed, eu);
    check({tag, "_tdata"}, m_tdata, ed);
    check({tag, "_tuser"}, 64'(m_tuser), 64'(eu));
    check({tag, "_tlast"}, 64'(m_tlast), 64'd1);
    check({tag, "_tstrb"}, 64'(m_tstrb), 64'hFF);
    for (int k = 0; k < hold_cycles; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_tdata"}, m_tdata, ed);
      check({tag, "_hold_stall"}, {62'd0, s_tready, m_tvalid}, 64'd1);
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    check({tag, "_post_hs"}, {62'd0, s_tready, m_tvalid}, 64'd2);
    frame_cnt_exp++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    frame_cnt_exp = 0;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", m_tdata, 64'd0);
    check("rst_tuser", 64'(m_tuser), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit tl;
    int thr;
    rst       = 1'b1;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    s_tdata   = '0;
    s_tstrb   = '1;
    threshold = '0;
    m_tready  = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Ramp 0..767 with tlast on the last beat.
    smp.delete();
    for (int i = 0; i < SPF; i++) smp.push_back(i);
    send_frame(SPF, 1'b1, 1000, 0);
    expect_result("ramp", SPF, 1'b1, 1000, 0);

    // Large value inside blanking window must be ignored.
    smp.delete();
    for (int i = 0; i < SPF; i++) smp.push_back(0);
    smp[3] = 5000; smp[100] = 200;
    send_frame(SPF, 1'b1, 150, 1);
    expect_result("blank", SPF, 1'b1, 150, 0);

    // Ties keep the earliest index.
    smp.delete();
    for (int i = 0; i < SPF; i++) smp.push_back(0);
    smp[50] = 42; smp[60] = 42;
    send_frame(SPF, 1'b1, 100, 0);
    expect_result("tie", SPF, 1'b1, 100, 2);

    // Early tlast at index 99, with a 10-cycle downstream stall.
    smp.delete();
    for (int i = 0; i < 100; i++) smp.push_back(rnd_sample());
    send_frame(100, 1'b1, 0, 1);
    expect_result("early", 100, 1'b1, 0, 10);

    // All -7.
    smp.delete();
    for (int i = 0; i < SPF; i++) smp.push_back(-7);
    send_frame(SPF, 1'b1, -10, 0);
    expect_result("neg7", SPF, 1'b1, -10, 0);

    // Index reaches the nominal end without tlast.
    smp.delete();
    for (int i = 0; i < SPF; i++) smp.push_back(rnd_sample());
    send_frame(SPF, 1'b0, 5, 0);
    expect_result("no_tlast", SPF, 1'b0, 5, 1);

    // Frame entirely inside the blanking window.
    smp.delete();
    for (int i = 0; i < BLANK; i++) smp.push_back(1000);
    send_frame(BLANK, 1'b1, -2147483647, 0);
    expect_result("short", BLANK, 1'b1, -2147483647, 0);

    // Single sample past the blanking window.
    smp.delete();
    for (int i = 0; i <= BLANK; i++) smp.push_back(i == BLANK ? -3 : 900);
    send_frame(BLANK + 1, 1'b1, -3, 0);
    expect_result("first_search", BLANK + 1, 1'b1, -3, 0);

    // Randomized frames.
    for (int r = 0; r < 8; r++) begin
      n  = int'($urandom_range(SPF, 1));
      tl = (n != SPF) || ($urandom_range(1, 0) == 1);
      thr = (r % 2 == 0) ? rnd_sample() : int'($urandom_range(200, 0)) - 100;
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back(rnd_sample());
      send_frame(n, tl, thr, (r % 3 == 0) ? 2 : 0);
      expect_result("rand", n, tl, thr, int'($urandom_range(3, 0)));
    end

    // Reset in the middle of a frame drops the partial frame.
    s_tvalid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_tdata = 32'(i * 10);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    do_reset();
    smp.delete();
    for (int i = 0; i < 40; i++) smp.push_back(i == 20 ? 77 : 1);
    send_frame(40, 1'b1, 77, 0);
    expect_result("after_rst", 40, 1'b1, 77, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
